// File: rtl/disp_cmd_writer.sv
// Host-side writer for the display command FIFO: serialises pixdata, font-load and
// raw requests into strobed bytes, pacing on the synchronised active-low full flag.
module disp_cmd_writer #(
    parameter int FONT_BYTES        = 4096,
    parameter int WR_LOW_CYCLES     = 2,
    parameter int WR_RECOVER_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_arg,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        nff_in,
    output logic        disp_cmd_wr,
    output logic [7:0]  disp_cmd_out,
    output logic        busy
);

    localparam logic [1:0] OP_PIX  = 2'b00;
    localparam logic [1:0] OP_FONT = 2'b01;
    localparam logic [1:0] OP_RAW  = 2'b10;
    localparam int CMAX = (WR_LOW_CYCLES > WR_RECOVER_CYCLES) ? WR_LOW_CYCLES : WR_RECOVER_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_STROBE, S_RECOVER, S_DROP} state_t;

    state_t          r_state, w_next;
    logic            r_nff_s1, r_nff_s2;
    logic [CW-1:0]   r_cnt;
    logic [12:0]     r_rem;
    logic [1:0]      r_op;
    logic [7:0]      r_arg;
    logic            r_font_byte;
    logic            r_wr;
    logic [7:0]      r_out;
    logic [11:0]     r_font_addr;
    logic            w_accept;
    logic            w_cnt_done;
    logic            w_last;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_cnt_done = (r_cnt == '0);
    assign w_last     = (r_rem == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = (cmd_op == 2'b11) ? S_DROP : S_WAIT;
            S_DROP:    w_next = S_IDLE;
            S_WAIT:    if (r_nff_s2) w_next = S_STROBE;
            S_STROBE:  if (w_cnt_done) w_next = S_RECOVER;
            S_RECOVER: if (w_cnt_done) w_next = w_last ? S_IDLE : S_WAIT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != S_IDLE);
        cmd_ready    = !busy && !rst;
        disp_cmd_wr  = r_wr;
        disp_cmd_out = r_out;
        font_addr    = r_font_addr;
    end

    // Strobe is registered from the next state so the FIFO sees a clean edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nff_s1    <= 1'b0;
            r_nff_s2    <= 1'b0;
            r_wr        <= 1'b1;
            r_out       <= 8'h00;
            r_font_addr <= 12'd0;
            r_cnt       <= '0;
            r_rem       <= 13'd0;
            r_op        <= 2'b00;
            r_arg       <= 8'h00;
            r_font_byte <= 1'b0;
        end else begin
            r_nff_s1 <= nff_in;
            r_nff_s2 <= r_nff_s1;
            r_wr     <= (w_next != S_STROBE);
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op        <= cmd_op;
                    r_arg       <= cmd_arg;
                    r_font_addr <= 12'd0;
                    r_font_byte <= 1'b0;
                    case (cmd_op)
                        OP_PIX:  begin r_out <= 8'h81;   r_rem <= 13'd1; end
                        OP_FONT: begin r_out <= 8'h80;   r_rem <= 13'(FONT_BYTES); end
                        OP_RAW:  begin r_out <= cmd_arg; r_rem <= 13'd0; end
                        default: r_rem <= 13'd0;
                    endcase
                end
                S_WAIT: if (r_nff_s2) r_cnt <= CW'(WR_LOW_CYCLES - 1);
                S_STROBE: begin
                    if (w_cnt_done) begin
                        r_cnt <= CW'(WR_RECOVER_CYCLES - 1);
                        if (r_font_byte) r_font_addr <= r_font_addr + 12'd1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_last) begin
                        // font_data has had at least two cycles to follow the address step
                        r_rem       <= r_rem - 13'd1;
                        r_out       <= (r_op == OP_FONT) ? font_data : r_arg;
                        r_font_byte <= (r_op == OP_FONT);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_cmd_writer.sv
// Directed bench for disp_cmd_writer with a rising-edge FIFO capture model and a
// registered font source returning 0x10+addr.
module tb_disp_cmd_writer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        nff_in;
    logic        disp_cmd_wr;
    logic [7:0]  disp_cmd_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  fifo [0:63];
    int          fifo_n = 0;
    int          fall_cyc [0:63];
    int          rise_cyc [0:63];
    int          fall_n = 0;
    int          rise_n = 0;
    logic [11:0] fa_log [0:63];
    int          fa_n = 0;

    disp_cmd_writer #(.FONT_BYTES(4), .WR_LOW_CYCLES(2), .WR_RECOVER_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .font_addr(font_addr), .font_data(font_data),
        .nff_in(nff_in), .disp_cmd_wr(disp_cmd_wr), .disp_cmd_out(disp_cmd_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(posedge clk) font_data <= 8'h10 + font_addr[7:0];

    always @(posedge disp_cmd_wr) if (!rst && fifo_n < 64) begin
        fifo[fifo_n] = disp_cmd_out;
        fifo_n++;
        if (rise_n < 64) begin rise_cyc[rise_n] = cyc; rise_n++; end
    end
    always @(negedge disp_cmd_wr) if (fall_n < 64) begin fall_cyc[fall_n] = cyc; fall_n++; end
    always @(font_addr) if (!rst && fa_n < 64) begin fa_log[fa_n] = font_addr; fa_n++; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (busy !== 1'b0 && k < maxc) begin @(negedge clk); k++; end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    int c0;
    int idle_cyc;

    initial begin
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 8'h5A; nff_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr",    {31'd0, disp_cmd_wr}, 32'd1);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_out",   {24'd0, disp_cmd_out}, 32'h00);
        chk("rst_faddr", {20'd0, font_addr}, 32'd0);
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_busy",  {31'd0, busy}, 32'd0);
        chk("no_strobe",      fall_n, 0);

        // pixdata 0x5A, FIFO never full
        issue(2'b00, 8'h5A);
        chk("pix_busy",  {31'd0, busy}, 32'd1);
        chk("pix_ready", {31'd0, cmd_ready}, 32'd0);
        chk("pix_out0",  {24'd0, disp_cmd_out}, 32'h81);
        chk("pix_wr_wait", {31'd0, disp_cmd_wr}, 32'd1);
        wait_idle(100);
        idle_cyc = cyc;
        chk("pix_cnt",    fifo_n, 2);
        chk("pix_b0",     {24'd0, fifo[0]}, 32'h81);
        chk("pix_b1",     {24'd0, fifo[1]}, 32'h5A);
        chk("pix_low0",   rise_cyc[0] - fall_cyc[0], 2);
        chk("pix_low1",   rise_cyc[1] - fall_cyc[1], 2);
        chk("pix_period", fall_cyc[1] - fall_cyc[0], 6);
        chk("pix_idle",   idle_cyc - fall_cyc[0], 11);
        chk("pix_ready_end", {31'd0, cmd_ready}, 32'd1);

        // raw 0xC3 stalled on a full FIFO
        nff_in = 1'b0;
        repeat (3) @(negedge clk);
        issue(2'b10, 8'hC3);
        repeat (10) @(negedge clk);
        chk("raw_stall_out",  {24'd0, disp_cmd_out}, 32'hC3);
        chk("raw_stall_wr",   {31'd0, disp_cmd_wr}, 32'd1);
        chk("raw_stall_busy", {31'd0, busy}, 32'd1);
        chk("raw_stall_cnt",  fifo_n, 2);
        nff_in = 1'b1;
        c0 = cyc;
        wait_idle(100);
        chk("raw_fall_delay", fall_cyc[2] - c0, 3);
        chk("raw_cnt",  fifo_n, 3);
        chk("raw_byte", {24'd0, fifo[2]}, 32'hC3);

        // reserved op is swallowed for one cycle
        issue(2'b11, 8'hAA);
        chk("rsv_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("rsv_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rsv_cnt", fifo_n, 3);

        // font load with a raw request held pending behind it
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'h00;
        @(negedge clk);
        cmd_op = 2'b10; cmd_arg = 8'hEE;
        chk("font_faddr0", {20'd0, font_addr}, 32'd0);
        chk("font_out0", {24'd0, disp_cmd_out}, 32'h80);
        wait_idle(200);
        chk("font_cnt", fifo_n, 8);
        chk("font_faddr_end", {20'd0, font_addr}, 32'd4);
        chk("font_steps", fa_n, 4);
        for (int i = 0; i < 4; i++) chk("font_step_val", {20'd0, fa_log[i]}, i + 1);
        chk("font_hdr", {24'd0, fifo[3]}, 32'h80);
        for (int i = 0; i < 4; i++) chk("font_byte", {24'd0, fifo[4 + i]}, 32'h10 + i);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("held_busy", {31'd0, busy}, 32'd1);
        wait_idle(100);
        chk("held_cnt",  fifo_n, 9);
        chk("held_byte", {24'd0, fifo[8]}, 32'hEE);

        // reset during the strobe of the second pixdata byte
        issue(2'b00, 8'h77);
        begin
            int k = 0;
            while (fifo_n < 10 && k < 50) begin @(negedge clk); k++; end
            k = 0;
            while (disp_cmd_wr !== 1'b0 && k < 50) begin @(negedge clk); k++; end
        end
        chk("abort_in_strobe", {31'd0, disp_cmd_wr}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_wr",    {31'd0, disp_cmd_wr}, 32'd1);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cnt",  fifo_n, 10);
        chk("abort_byte", {24'd0, fifo[9]}, 32'h81);
        chk("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        issue(2'b10, 8'h3C);
        wait_idle(100);
        chk("after_cnt",  fifo_n, 11);
        chk("after_byte", {24'd0, fifo[10]}, 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
